// File: rtl/led_pattern_ctrl_if.sv
// Pin-side bundle for led_pattern_ctrl: raw board inputs in, registered LED-side outputs out.
interface led_pattern_ctrl_if;
   logic       btn_mode;
   logic       btn_speed;
   logic       sw_pause;
   logic [7:0] led;
   logic [1:0] mode;
   logic [1:0] speed;
   logic       tick;

   modport master (output btn_mode, btn_speed, sw_pause,
                   input  led, mode, speed, tick);
   modport slave  (input  btn_mode, btn_speed, sw_pause,
                   output led, mode, speed, tick);
endinterface

// File: rtl/led_pattern_ctrl.sv
// 8-LED pattern sequencer: button/switch conditioning, speed prescaler and pattern register.
// Optional button debouncing is built in when LED_CTRL_DEBOUNCE_EN is defined.
//
// state (mode) | meaning
// ROT_L        | rotate led left each step
// ROT_R        | rotate led right each step
// BOUNCE       | single lit LED walks to an end and reverses (dir tracks heading)
// BLINK        | invert all LEDs each step
module led_pattern_ctrl #(
   parameter int unsigned TICK_DIV     = 50000000,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DEBOUNCE_CYC = 1000000
) (
   input logic               clk,
   input logic               rst_n,
   led_pattern_ctrl_if.slave io
);
   typedef enum logic [1:0] {ROT_L = 2'd0, ROT_R = 2'd1, BOUNCE = 2'd2, BLINK = 2'd3} mode_e;
   typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

   logic [2:0]       sync1, sync2;   // {pause, speed, mode}
   logic [1:0]       btn_lvl, btn_prev, btn_pulse;
   logic             paused, mode_pulse, speed_pulse, step_evt;
   mode_e            mode_q, mode_d;
   dir_e             dir_q, dir_d;
   logic [1:0]       speed_q, speed_d;
   logic [7:0]       led_q, led_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, limit;
   logic             tick_q, tick_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {io.sw_pause, io.btn_speed, io.btn_mode};
         sync2 <= sync1;
      end
   end

   assign paused = sync2[2];

`ifdef LED_CTRL_DEBOUNCE_EN
   localparam int unsigned     DB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYC - 1);

   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      db_lvl;

   // Filtered level flips only once the synchronized level has disagreed for DEBOUNCE_CYC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_lvl    <= '0;
         db_cnt[0] <= DB_LOAD;
         db_cnt[1] <= DB_LOAD;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != db_lvl[i]) begin
               if (db_cnt[i] == '0) begin
                  db_lvl[i] <= sync2[i];
                  db_cnt[i] <= DB_LOAD;
               end else begin
                  db_cnt[i] <= db_cnt[i] - 1'b1;
               end
            end else begin
               db_cnt[i] <= DB_LOAD;
            end
         end
      end
   end

   assign btn_lvl = db_lvl;
`else
   assign btn_lvl = sync2[1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev  <= '0;
         btn_pulse <= '0;
      end else begin
         btn_prev  <= btn_lvl;
         btn_pulse <= btn_lvl & ~btn_prev;
      end
   end

   assign mode_pulse  = btn_pulse[0];
   assign speed_pulse = btn_pulse[1];

   assign limit    = CNT_W'(TICK_DIV) >> speed_q;
   assign step_evt = !paused && (cnt_q == limit - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= ROT_L;
         dir_q   <= DIR_LEFT;
         speed_q <= '0;
         led_q   <= 8'h01;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         speed_q <= speed_d;
         led_q   <= led_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
      end
   end

   // Button events pre-empt a coincident step; the pre-empted step is dropped, not queued.
   always_comb begin
      mode_d  = mode_q;
      dir_d   = dir_q;
      speed_d = speed_q;
      led_d   = led_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      if (mode_pulse) begin
         mode_d = mode_e'(mode_q + 2'd1);
         led_d  = (mode_q == BOUNCE) ? 8'hFF : 8'h01;
         dir_d  = DIR_LEFT;
         cnt_d  = '0;
      end else if (speed_pulse) begin
         speed_d = speed_q + 2'd1;
         cnt_d   = '0;
      end else if (step_evt) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         case (mode_q)
            ROT_L:  led_d = {led_q[6:0], led_q[7]};
            ROT_R:  led_d = {led_q[0], led_q[7:1]};
            BOUNCE: begin
               if (dir_q == DIR_LEFT) begin
                  if (led_q == 8'h80) begin
                     dir_d = DIR_RIGHT;
                     led_d = 8'h40;
                  end else begin
                     led_d = {led_q[6:0], 1'b0};
                  end
               end else begin
                  if (led_q == 8'h01) begin
                     dir_d = DIR_LEFT;
                     led_d = 8'h02;
                  end else begin
                     led_d = {1'b0, led_q[7:1]};
                  end
               end
            end
            BLINK:   led_d = ~led_q;
            default: led_d = led_q;
         endcase
      end else if (!paused) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign io.led   = led_q;
   assign io.mode  = mode_q;
   assign io.speed = speed_q;
   assign io.tick  = tick_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl at TICK_DIV=8; LED_CTRL_DEBOUNCE_EN selects the debounce scenario.
module tb_led_pattern_ctrl;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   logic seen;
   logic [7:0] rotl_exp   [8];
   logic [7:0] bounce_exp [16];

   led_pattern_ctrl_if bus ();

   led_pattern_ctrl #(
      .TICK_DIV     (8),
      .CNT_W        (32),
      .DEBOUNCE_CYC (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.btn_mode  = 1'b0;
      bus.btn_speed = 1'b0;
      bus.sw_pause  = 1'b0;
      rotl_exp   = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
      bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
      #12;
      check("rst_led",   32'(bus.led),   32'h01);
      check("rst_mode",  32'(bus.mode),  32'd0);
      check("rst_speed", 32'(bus.speed), 32'd0);
      check("rst_tick",  32'(bus.tick),  32'd0);
      rst_n = 1'b1;

`ifdef LED_CTRL_DEBOUNCE_EN
      step(2);
      bus.btn_mode = 1'b1;
      step(3);
      bus.btn_mode = 1'b0;
      step(15);
      check("db_glitch_mode", 32'(bus.mode), 32'd0);
      bus.btn_mode = 1'b1;
      step(10);
      bus.btn_mode = 1'b0;
      step(10);
      check("db_press_mode", 32'(bus.mode), 32'd1);
`else
      // ROT_L free-running from reset
      step(7);
      check("first_pre_tick", 32'(bus.tick), 32'd0);
      check("first_pre_led",  32'(bus.led),  32'h01);
      step(1);
      check("first_tick",     32'(bus.tick), 32'd1);
      check("first_led",      32'(bus.led),  32'h02);
      for (int i = 0; i < 8; i++) begin
         step(8);
         check("rotl_tick", 32'(bus.tick), 32'd1);
         check("rotl_led",  32'(bus.led),  32'(rotl_exp[i]));
      end
      check("rotl_mode",  32'(bus.mode),  32'd0);
      check("rotl_speed", 32'(bus.speed), 32'd0);

      // one mode press -> ROT_R
      bus.btn_mode = 1'b1;
      step(4);
      check("rotr_mode", 32'(bus.mode), 32'd1);
      check("rotr_seed", 32'(bus.led),  32'h01);
      check("rotr_tick0", 32'(bus.tick), 32'd0);
      bus.btn_mode = 1'b0;
      step(8);
      check("rotr_tick1", 32'(bus.tick), 32'd1);
      check("rotr_led1",  32'(bus.led),  32'h80);
      step(8);
      check("rotr_led2",  32'(bus.led),  32'h40);

      // -> BOUNCE, 16 steps across both ends
      bus.btn_mode = 1'b1;
      step(4);
      check("bounce_mode", 32'(bus.mode), 32'd2);
      check("bounce_seed", 32'(bus.led),  32'h01);
      bus.btn_mode = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(8);
         check("bounce_tick", 32'(bus.tick), 32'd1);
         check("bounce_led",  32'(bus.led),  32'(bounce_exp[i]));
      end

      // speed presses
      bus.btn_speed = 1'b1;
      step(4);
      check("spd1_speed", 32'(bus.speed), 32'd1);
      check("spd1_tick0", 32'(bus.tick),  32'd0);
      bus.btn_speed = 1'b0;
      step(4);
      check("spd1_tick",  32'(bus.tick),  32'd1);
      check("spd1_led",   32'(bus.led),   32'h08);
      bus.btn_speed = 1'b1;
      step(4);
      check("spd2_speed", 32'(bus.speed), 32'd2);
      check("spd2_tick0", 32'(bus.tick),  32'd0);
      check("spd2_led0",  32'(bus.led),   32'h08);
      bus.btn_speed = 1'b0;
      step(4);
      check("spd2_tick",  32'(bus.tick),  32'd1);
      check("spd2_led",   32'(bus.led),   32'h20);
      bus.btn_speed = 1'b1;
      step(4);
      check("spd3_speed", 32'(bus.speed), 32'd3);
      check("spd3_tick0", 32'(bus.tick),  32'd0);
      check("spd3_led0",  32'(bus.led),   32'h40);
      bus.btn_speed = 1'b0;
      step(1);
      check("spd3_t1", 32'(bus.tick), 32'd1);
      check("spd3_l1", 32'(bus.led),  32'h80);
      step(1);
      check("spd3_t2", 32'(bus.tick), 32'd1);
      check("spd3_l2", 32'(bus.led),  32'h40);
      step(1);
      check("spd3_l3", 32'(bus.led),  32'h20);
      step(1);
      check("spd3_l4", 32'(bus.led),  32'h10);
      bus.btn_speed = 1'b1;
      step(4);
      check("spd0_speed", 32'(bus.speed), 32'd0);
      check("spd0_tick0", 32'(bus.tick),  32'd0);
      check("spd0_led0",  32'(bus.led),   32'h02);
      bus.btn_speed = 1'b0;
      step(7);
      check("spd0_pre",   32'(bus.tick),  32'd0);
      step(1);
      check("spd0_tick",  32'(bus.tick),  32'd1);
      check("spd0_led",   32'(bus.led),   32'h01);

      // pause, then mode press while paused
      bus.sw_pause = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         seen |= bus.tick;
      end
      check("pause_tick", 32'(seen),    32'd0);
      check("pause_led",  32'(bus.led), 32'h01);
      bus.btn_mode = 1'b1;
      step(4);
      check("pause_mode",   32'(bus.mode), 32'd3);
      check("pause_reload", 32'(bus.led),  32'hFF);
      check("pause_tick0",  32'(bus.tick), 32'd0);
      bus.btn_mode = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         seen |= bus.tick;
      end
      check("pause2_tick", 32'(seen),    32'd0);
      check("pause2_led",  32'(bus.led), 32'hFF);
      bus.sw_pause = 1'b0;
      step(9);
      check("unpause_pre",  32'(bus.tick), 32'd0);
      step(1);
      check("blink_tick",   32'(bus.tick), 32'd1);
      check("blink_led",    32'(bus.led),  32'h00);

      // mode pulse lands on the same cycle as a step
      step(4);
      bus.btn_mode = 1'b1;
      step(4);
      check("coinc_mode", 32'(bus.mode), 32'd0);
      check("coinc_led",  32'(bus.led),  32'h01);
      check("coinc_tick", 32'(bus.tick), 32'd0);
      bus.btn_mode = 1'b0;
      step(8);
      check("coinc_next_tick", 32'(bus.tick), 32'd1);
      check("coinc_next_led",  32'(bus.led),  32'h02);

      // walk to BLINK, then async reset mid-cycle
      for (int i = 0; i < 3; i++) begin
         bus.btn_mode = 1'b1;
         step(4);
         bus.btn_mode = 1'b0;
         if (i < 2) step(4);
      end
      check("pre_rst_mode", 32'(bus.mode), 32'd3);
      check("pre_rst_led",  32'(bus.led),  32'hFF);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_led",  32'(bus.led),  32'h01);
      check("async_rst_mode", 32'(bus.mode), 32'd0);
      check("async_rst_tick", 32'(bus.tick), 32'd0);
      step(2);
      rst_n = 1'b1;
      step(7);
      check("rerun_pre",  32'(bus.tick), 32'd0);
      step(1);
      check("rerun_tick", 32'(bus.tick), 32'd1);
      check("rerun_led",  32'(bus.led),  32'h02);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
